// File: rtl/adsr_pkg.sv
// Shared constants and phase encoding for the ADSR envelope generator.
package adsr_pkg;

  localparam int unsigned AMP_W   = 6;
  localparam int unsigned RATE_W  = 8;
  localparam int unsigned PHASE_W = 3;
  localparam logic [AMP_W-1:0] AMP_MAX = 6'd63;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clk tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_count;
  logic             r_tick;

  // tick is registered one count early so it is high exactly while count==TICK_DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      if (r_count == CNT_W'(TICK_DIV - 1))
        r_count <= '0;
      else
        r_count <= r_count + CNT_W'(1);
      r_tick <= (r_count == CNT_W'(TICK_DIV - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope: key gate + rate/level knobs -> 6-bit amplitude for the oscillator bank.
// Optional ADSR_EXP_RELEASE_EN: release steps subtract (amp>>3)+1 for an exponential-like tail.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned TICK_HZ         = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [AMP_W-1:0]  sustain_level,
  input  logic [RATE_W-1:0] release_rate,
  output logic [AMP_W-1:0]  amplitude,
  output logic [PHASE_W-1:0] phase,
  output logic              busy
);

  localparam int unsigned TICK_DIV = CLOCK_FREQUENCY / TICK_HZ;

  phase_e              r_phase, w_phase_nxt;
  logic [AMP_W-1:0]    r_amp, w_amp_nxt;
  logic [RATE_W-1:0]   r_step_cnt, w_step_cnt_nxt;
  logic                r_busy;
  logic                w_tick;
  logic                w_step;
  logic                w_counting;
  logic [RATE_W-1:0]   w_rate;
  logic [AMP_W-1:0]    w_rel_amp;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Rate for the active phase, sampled live
  always_comb begin
    w_rate     = '0;
    w_counting = 1'b0;
    case (r_phase)
      PH_ATTACK:  begin w_rate = attack_rate;  w_counting = 1'b1; end
      PH_DECAY:   begin w_rate = decay_rate;   w_counting = 1'b1; end
      PH_RELEASE: begin w_rate = release_rate; w_counting = 1'b1; end
      default:    begin w_rate = '0;           w_counting = 1'b0; end
    endcase
  end

  // >= so that lowering a rate below the current count fires on the next tick
  assign w_step = w_tick && w_counting && (r_step_cnt >= w_rate);

`ifdef ADSR_EXP_RELEASE_EN
  logic [AMP_W-1:0] w_rel_dec;
  assign w_rel_dec = AMP_W'(r_amp >> 3) + AMP_W'(1);
  assign w_rel_amp = (r_amp > w_rel_dec) ? (r_amp - w_rel_dec) : '0;
`else
  assign w_rel_amp = (r_amp != '0) ? (r_amp - AMP_W'(1)) : '0;
`endif

  // Next-state / next-amplitude; gate changes pre-empt level transitions and steps
  always_comb begin
    w_phase_nxt    = r_phase;
    w_amp_nxt      = r_amp;
    w_step_cnt_nxt = r_step_cnt;

    if (w_tick && w_counting)
      w_step_cnt_nxt = w_step ? '0 : (r_step_cnt + RATE_W'(1));

    case (r_phase)
      PH_IDLE: begin
        w_amp_nxt = '0;
        if (gate)
          w_phase_nxt = PH_ATTACK;
      end
      PH_ATTACK: begin
        if (!gate)
          w_phase_nxt = PH_RELEASE;
        else if (r_amp == AMP_MAX)
          w_phase_nxt = PH_DECAY;
        else if (w_step)
          w_amp_nxt = r_amp + AMP_W'(1);
      end
      PH_DECAY: begin
        if (!gate)
          w_phase_nxt = PH_RELEASE;
        else if (r_amp <= sustain_level)
          w_phase_nxt = PH_SUSTAIN;
        else if (w_step)
          w_amp_nxt = r_amp - AMP_W'(1);
      end
      PH_SUSTAIN: begin
        if (!gate)
          w_phase_nxt = PH_RELEASE;
        else
          w_amp_nxt = sustain_level;
      end
      PH_RELEASE: begin
        if (gate)
          w_phase_nxt = PH_ATTACK;
        else if (r_amp == '0)
          w_phase_nxt = PH_IDLE;
        else if (w_step)
          w_amp_nxt = w_rel_amp;
      end
      default: begin
        w_phase_nxt = PH_IDLE;
        w_amp_nxt   = '0;
      end
    endcase

    if (w_phase_nxt != r_phase)
      w_step_cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= PH_IDLE;
      r_amp      <= '0;
      r_step_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_amp      <= w_amp_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_busy     <= (w_phase_nxt != PH_IDLE);
    end
  end

  assign amplitude = r_amp;
  assign phase     = r_phase;
  assign busy      = r_busy;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed testbench for adsr_envelope with TICK_DIV=10 (100 Hz clock, 10 Hz tick).
module tb_adsr_envelope;

  logic       clk;
  logic       reset;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [5:0] sustain_level;
  logic [7:0] release_rate;
  logic [5:0] amplitude;
  logic [2:0] phase;
  logic       busy;

  int checks;
  int errors;

  adsr_envelope #(
    .CLOCK_FREQUENCY (100),
    .TICK_HZ         (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .amplitude     (amplitude),
    .phase         (phase),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; gate = 1'b0;
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 6'd0; release_rate = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (amplitude !== 6'd0 || phase !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: amp=%0d phase=%0d busy=%0b, want 0/0/0", amplitude, phase, busy);
    end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (amplitude !== 6'd0 || phase !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: amp=%0d phase=%0d busy=%0b, want 0/0/0", amplitude, phase, busy);
    end
  endtask

  task automatic test_reset_mid_attack();
    int n;
    gate = 1'b1; attack_rate = 8'd0;
    n = 0;
    while (amplitude !== 6'd20 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 1000 || phase !== 3'd1) begin
      errors++;
      $display("FAIL attack_to_20: amp=%0d phase=%0d after %0d clks, want 20/1", amplitude, phase, n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (amplitude !== 6'd0 || phase !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: amp=%0d phase=%0d busy=%0b, want 0/0/0", amplitude, phase, busy);
    end
    gate = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (amplitude !== 6'd0 || phase !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: amp=%0d phase=%0d busy=%0b, want 0/0/0", amplitude, phase, busy);
    end
  endtask

  task automatic test_attack_decay();
    int n;
    gate = 1'b1; attack_rate = 8'd0; decay_rate = 8'd1; sustain_level = 6'd40;
    n = 0;
    while (amplitude !== 6'd63 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n < 615 || n > 640) begin
      errors++;
      $display("FAIL attack_time: reached amp=%0d after %0d clks, want 63 in 615..640", amplitude, n);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd2 || amplitude !== 6'd63 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enter_decay: phase=%0d amp=%0d busy=%0b, want 2/63/1", phase, amplitude, busy);
    end
    n = 0;
    while (phase !== 3'd3 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n < 445 || n > 470 || amplitude !== 6'd40) begin
      errors++;
      $display("FAIL decay_time: phase=%0d amp=%0d after %0d clks, want 3/40 in 445..470", phase, amplitude, n);
    end
  endtask

  task automatic test_sustain_track();
    sustain_level = 6'd10;
    @(negedge clk);
    checks++;
    if (amplitude !== 6'd10 || phase !== 3'd3) begin
      errors++;
      $display("FAIL sustain_track: amp=%0d phase=%0d, want 10/3", amplitude, phase);
    end
  endtask

  task automatic test_release();
    int n;
    release_rate = 8'd0; gate = 1'b0;
    @(negedge clk);
    checks++;
    if (phase !== 3'd4 || amplitude !== 6'd10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enter_release: phase=%0d amp=%0d busy=%0b, want 4/10/1", phase, amplitude, busy);
    end
    n = 0;
    while (amplitude !== 6'd0 && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (n < 85 || n > 105) begin
      errors++;
      $display("FAIL release_time: amp=%0d after %0d clks, want 0 in 85..105", amplitude, n);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0 || amplitude !== 6'd0) begin
      errors++;
      $display("FAIL release_to_idle: phase=%0d busy=%0b amp=%0d, want 0/0/0", phase, busy, amplitude);
    end
  endtask

  task automatic test_retrigger();
    int n;
    gate = 1'b1; attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 6'd40;
    n = 0;
    while (phase !== 3'd3 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (phase !== 3'd3 || amplitude !== 6'd40) begin
      errors++;
      $display("FAIL retrig_setup: phase=%0d amp=%0d, want 3/40", phase, amplitude);
    end
    release_rate = 8'd0; gate = 1'b0;
    n = 0;
    while (amplitude !== 6'd35 && n < 200) begin @(negedge clk); n++; end
    gate = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 3'd1 || amplitude !== 6'd35 || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_phase: phase=%0d amp=%0d busy=%0b, want 1/35/1", phase, amplitude, busy);
    end
    n = 0;
    while (amplitude === 6'd35 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (amplitude !== 6'd36) begin
      errors++;
      $display("FAIL retrig_step1: amp=%0d, want 36", amplitude);
    end
    n = 0;
    while (amplitude === 6'd36 && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (amplitude !== 6'd37 || phase !== 3'd1) begin
      errors++;
      $display("FAIL retrig_step2: amp=%0d phase=%0d, want 37/1", amplitude, phase);
    end
  endtask

  task automatic test_full_release();
    int n;
    int idx;
    int nexp;
    int exp_seq[64];
    logic [5:0] prev;
`ifdef ADSR_EXP_RELEASE_EN
    int exp_tbl[21];
    exp_tbl = '{63, 55, 48, 41, 35, 30, 26, 22, 19, 16, 13, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    nexp = 21;
    for (int i = 0; i < 21; i++) exp_seq[i] = exp_tbl[i];
`else
    nexp = 64;
    for (int i = 0; i < 64; i++) exp_seq[i] = 63 - i;
`endif
    sustain_level = 6'd63; decay_rate = 8'd0;
    n = 0;
    while (phase !== 3'd3 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (phase !== 3'd3 || amplitude !== 6'd63) begin
      errors++;
      $display("FAIL peak_sustain: phase=%0d amp=%0d, want 3/63", phase, amplitude);
    end
    release_rate = 8'd0; gate = 1'b0;
    prev = amplitude;
    idx = 1;
    n = 0;
    while (amplitude !== 6'd0 && n < 1000 && idx < nexp) begin
      @(negedge clk); n++;
      if (amplitude !== prev) begin
        checks++;
        if (int'(amplitude) != exp_seq[idx]) begin
          errors++;
          $display("FAIL release_seq[%0d]: amp=%0d, want %0d", idx, amplitude, exp_seq[idx]);
        end
        prev = amplitude;
        idx++;
      end
    end
    checks++;
    if (amplitude !== 6'd0 || idx != nexp) begin
      errors++;
      $display("FAIL release_end: amp=%0d steps=%0d, want 0 after %0d steps", amplitude, idx - 1, nexp - 1);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0 || amplitude !== 6'd0) begin
      errors++;
      $display("FAIL final_idle: phase=%0d busy=%0b amp=%0d, want 0/0/0", phase, busy, amplitude);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (phase !== 3'd0 || amplitude !== 6'd0) begin
      errors++;
      $display("FAIL no_underflow: phase=%0d amp=%0d, want 0/0", phase, amplitude);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_attack();
    test_attack_decay();
    test_sustain_track();
    test_release();
    test_retrigger();
    test_full_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
